lavatorio_arbiter: RTL and testbench
====================================

Name: lavatorio_arbiter

Overview:
Sequential arbiter for the aircraft's three lavatories. Lavatory A is women-only; B and C are shared. The block queues passenger call requests per class, grants free lavatories, and holds each grant as a reservation until the door locks or a timeout expires. It drives the availability LEDs from tracked lavatory state rather than from raw door sensors, and sits between the call-button/door-sensor inputs and the cabin indicators.

Parameters:
TIMEOUT, 8, clk_2 cycles a reservation is held before it is released (minimum 2)
QW, 4, width of each waiting-queue counter

Ports:
clk_2  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_mulher  input  1  single-cycle pulse: one woman joins queue
req_homem  input  1  single-cycle pulse: one man joins queue
porta  input  3  door lock sensors [0]=A [1]=B [2]=C; 1=locked
grant  output  3  one-hot single-cycle pulse: lavatory granted
grant_mulher  output  1  pulse with grant: grantee is a woman
grant_homem  output  1  pulse with grant: grantee is a man
timeout  output  3  single-cycle pulse per lavatory: reservation expired
livre_mulher  output  1  some lavatory usable by a woman is LIVRE
livre_homem  output  1  B or C is LIVRE
fila_mulher  output  QW  women waiting
fila_homem  output  QW  men waiting

Behaviour:
- Reset (asynchronous, active-low): all lavatories LIVRE; timers 0; queues 0; all outputs 0; prio favours women; rr points to B.
- Per-lavatory FSM, one per lavatory:
  - LIVRE: porta=1 -> OCUPADO (unsolicited entry). Grant -> RESERVADO, timer cleared.
  - RESERVADO: porta=1 -> OCUPADO. Otherwise timer++. When timer==TIMEOUT-1 -> LIVRE, with timeout[i]=1 for one cycle.
  - OCUPADO: porta=0 -> LIVRE.
  - porta=1 takes precedence over timer expiry in the same cycle.
- Eligibility ("free"): a lavatory is free only if state==LIVRE and porta==0 in that cycle.
- Candidates each cycle:
  - Woman candidate: fila_mulher>0 and A, B or C free. Choice order: A, then B, then C.
  - Man candidate: fila_homem>0 and B or C free. If both are free, choose rr; otherwise the free one.
- At most one grant per cycle. If both classes are candidates, prio decides. After any grant, prio switches to favour the other class. rr flips after any grant to B or C.
- Output timing: grant, grant_mulher and grant_homem are registered. They assert on the same edge that moves the granted FSM to RESERVADO and decrements the matching queue. Latency is 1 cycle from the conditions being met.
- Queues:
  - +1 on req, -1 on grant.
  - Request and grant together: count unchanged.
  - Saturate at 2^QW-1; a request at full is dropped.
  - Never decrement below 0.
  - A timed-out grantee is not requeued.
- livre_mulher and livre_homem: registered from next-state FSM values (LIVRE only); reserved lavatories count as not free.
- No requests pending: FSMs follow porta only, and no grants are issued.

Decomposition:
- Package lavatorio_pkg:
  - typedef enum logic [1:0] {LIVRE, RESERVADO, OCUPADO} lav_state_t
  - constants LAV_A=0, LAV_B=1, LAV_C=2
  - typedef for the one-hot 3-bit lavatory vector
- Sub-module lavatorio_fsm, instantiated 3x:
  - inputs: clk_2, reset_n, porta_i, grant_i
  - outputs: state, timeout pulse
  - parameter: TIMEOUT
- The top level holds the queues, prio/rr registers and grant selection.

Test Plan:
- Reset mid-reservation: grant B, pull reset_n low 3 cycles later -> all outputs 0, queues 0, livre_* =1 after release with porta=000.
- Women preference: porta=000, one req_mulher -> next edge grant=001, grant_mulher=1, fila_mulher 1->0, livre_mulher stays 1 (B/C free).
- Contention: fila_mulher=1, fila_homem=1, only C free (A,B OCUPADO), prio=women -> grant=100 to woman; free C again -> man granted C; prio alternates.
- Timeout: grant B, hold porta=000 -> timeout=010 exactly TIMEOUT cycles after grant, B back to LIVRE, queue not restored.
- Door wins: grant C, then set porta[2]=1 on cycle TIMEOUT-1 -> C OCUPADO, no timeout pulse; porta[2]=0 -> LIVRE.
- Saturation/simultaneity: 16 req_homem pulses with QW=4 and all doors locked -> fila_homem=15; req_homem coinciding with a man grant -> count unchanged.

Source files
------------

// File: rtl/lavatorio_pkg.sv
// lavatorio_pkg: shared lavatory state encoding, indices and vector type
package lavatorio_pkg;
  typedef enum logic [1:0] {LIVRE, RESERVADO, OCUPADO} lav_state_t;
  localparam int LAV_A = 0;
  localparam int LAV_B = 1;
  localparam int LAV_C = 2;
  typedef logic [2:0] lav_vec_t;
endpackage

// File: rtl/lavatorio_fsm.sv
// lavatorio_fsm: per-lavatory LIVRE/RESERVADO/OCUPADO tracker with reservation timeout
module lavatorio_fsm
  import lavatorio_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       porta_i,
  input  logic       grant_i,
  output lav_state_t state,
  output lav_state_t state_nxt,
  output logic       timeout
);
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] timer;
  logic expire;
  always_comb begin
    expire = state == RESERVADO && !porta_i && timer == TW'(TIMEOUT - 1);
    state_nxt = porta_i ? OCUPADO :
                state == OCUPADO ? LIVRE :
                state == LIVRE ? (grant_i ? RESERVADO : LIVRE) :
                (expire ? LIVRE : RESERVADO);
  end
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LIVRE;
      timer   <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      timeout <= expire;
      timer   <= (state == RESERVADO && state_nxt == RESERVADO) ? timer + TW'(1) : '0;
    end
  end
endmodule

// File: rtl/lavatorio_arbiter.sv
// lavatorio_arbiter: queues lavatory calls per class and grants/reserves free lavatories
module lavatorio_arbiter
  import lavatorio_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int QW      = 4
) (
  input  logic          clk_2,
  input  logic          reset_n,
  input  logic          req_mulher,
  input  logic          req_homem,
  input  logic [2:0]    porta,
  output logic [2:0]    grant,
  output logic          grant_mulher,
  output logic          grant_homem,
  output logic [2:0]    timeout,
  output logic          livre_mulher,
  output logic          livre_homem,
  output logic [QW-1:0] fila_mulher,
  output logic [QW-1:0] fila_homem
);
  lav_state_t st [3];
  lav_state_t st_nxt [3];
  lav_vec_t free, w_sel, m_sel, sel;
  logic w_cand, m_cand, pick_w, pick_m, prio, rr;
  for (genvar i = 0; i < 3; i++) begin : g_lav
    lavatorio_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
      .clk_2     (clk_2),
      .reset_n   (reset_n),
      .porta_i   (porta[i]),
      .grant_i   (sel[i]),
      .state     (st[i]),
      .state_nxt (st_nxt[i]),
      .timeout   (timeout[i])
    );
    assign free[i] = st[i] == LIVRE && !porta[i];
  end
  always_comb begin
    w_cand = fila_mulher != '0 && |free;
    m_cand = fila_homem != '0 && (free[LAV_B] || free[LAV_C]);
    w_sel  = free[LAV_A] ? 3'b001 : free[LAV_B] ? 3'b010 : 3'b100;
    m_sel  = (free[LAV_B] && free[LAV_C]) ? (rr ? 3'b100 : 3'b010) :
             free[LAV_B] ? 3'b010 : 3'b100;
    pick_w = w_cand && (!m_cand || !prio);
    pick_m = m_cand && !pick_w;
    sel    = pick_w ? w_sel : pick_m ? m_sel : '0;
  end
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= '0;
      grant_mulher <= 1'b0;
      grant_homem  <= 1'b0;
      livre_mulher <= 1'b0;
      livre_homem  <= 1'b0;
      fila_mulher  <= '0;
      fila_homem   <= '0;
      prio         <= 1'b0;
      rr           <= 1'b0;
    end else begin
      grant        <= sel;
      grant_mulher <= pick_w;
      grant_homem  <= pick_m;
      if (pick_w || pick_m) prio <= pick_w;
      if (sel[LAV_B] || sel[LAV_C]) rr <= !rr;
      fila_mulher  <= fila_mulher + QW'(req_mulher && !pick_w && !(&fila_mulher))
                                  - QW'(pick_w && !req_mulher);
      fila_homem   <= fila_homem + QW'(req_homem && !pick_m && !(&fila_homem))
                                 - QW'(pick_m && !req_homem);
      livre_mulher <= st_nxt[LAV_A] == LIVRE || st_nxt[LAV_B] == LIVRE || st_nxt[LAV_C] == LIVRE;
      livre_homem  <= st_nxt[LAV_B] == LIVRE || st_nxt[LAV_C] == LIVRE;
    end
  end
endmodule

// File: tb/tb_lavatorio_arbiter.sv
// tb_lavatorio_arbiter: table and scoreboard driven check of lavatorio_arbiter
module tb_lavatorio_arbiter;
  localparam int T = 8;
  localparam int QW = 4;
  localparam int N = 25;
  logic clk_2 = 1'b0;
  logic reset_n = 1'b0;
  logic req_mulher = 1'b0;
  logic req_homem = 1'b0;
  logic [2:0] porta = 3'b000;
  logic [2:0] grant, timeout;
  logic grant_mulher, grant_homem, livre_mulher, livre_homem;
  logic [QW-1:0] fila_mulher, fila_homem;
  logic [17:0] outs;
  typedef struct {
    logic rm;
    logic rh;
    logic [2:0] p;
    logic [17:0] e;
  } vec_t;
  vec_t tbl [N];
  logic [17:0] sb [$];
  int total = 0;
  int bad = 0;
  lavatorio_arbiter #(.TIMEOUT(T), .QW(QW)) dut (
    .clk_2        (clk_2),
    .reset_n      (reset_n),
    .req_mulher   (req_mulher),
    .req_homem    (req_homem),
    .porta        (porta),
    .grant        (grant),
    .grant_mulher (grant_mulher),
    .grant_homem  (grant_homem),
    .timeout      (timeout),
    .livre_mulher (livre_mulher),
    .livre_homem  (livre_homem),
    .fila_mulher  (fila_mulher),
    .fila_homem   (fila_homem)
  );
  assign outs = {grant, grant_mulher, grant_homem, timeout, livre_mulher, livre_homem, fila_mulher, fila_homem};
  always #5 clk_2 = ~clk_2;
  function automatic logic [17:0] ex(int g, int gm, int gh, int to, int lm, int lh, int fm, int fh);
    return {3'(g), 1'(gm), 1'(gh), 3'(to), 1'(lm), 1'(lh), 4'(fm), 4'(fh)};
  endfunction
  task automatic put(int i, int rm, int rh, int p, logic [17:0] e);
    tbl[i] = '{1'(rm), 1'(rh), 3'(p), e};
  endtask
  task automatic chk(string nm, logic [17:0] got, logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got g/gm/gh/to/lm/lh/fm/fh=%b_%b_%b_%b_%b_%b_%h_%h required=%b_%b_%b_%b_%b_%b_%h_%h",
               nm, got[17:15], got[14], got[13], got[12:10], got[9], got[8], got[7:4], got[3:0],
               exp[17:15], exp[14], exp[13], exp[12:10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask
  task automatic step(int rm, int rh, int p, logic [17:0] e, string nm);
    req_mulher = 1'(rm);
    req_homem  = 1'(rh);
    porta      = 3'(p);
    sb.push_back(e);
    @(posedge clk_2);
    #1;
    req_mulher = 1'b0;
    req_homem  = 1'b0;
    chk(nm, outs, sb.pop_front());
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    put(0,  0, 0, 3'b000, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 0));
    put(1,  1, 0, 3'b000, ex(3'b000, 0, 0, 3'b000, 1, 1, 1, 0));
    put(2,  0, 0, 3'b000, ex(3'b001, 1, 0, 3'b000, 1, 1, 0, 0));
    put(3,  0, 0, 3'b001, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 0));
    put(4,  0, 1, 3'b001, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 1));
    put(5,  0, 0, 3'b001, ex(3'b010, 0, 1, 3'b000, 1, 1, 0, 0));
    put(6,  0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 0));
    put(7,  0, 1, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 1));
    put(8,  0, 1, 3'b011, ex(3'b100, 0, 1, 3'b000, 0, 0, 0, 1));
    put(9,  0, 0, 3'b111, ex(3'b000, 0, 0, 3'b000, 0, 0, 0, 1));
    put(10, 1, 0, 3'b111, ex(3'b000, 0, 0, 3'b000, 0, 0, 1, 1));
    put(11, 0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 1, 1));
    put(12, 0, 0, 3'b011, ex(3'b100, 1, 0, 3'b000, 0, 0, 0, 1));
    put(13, 0, 0, 3'b111, ex(3'b000, 0, 0, 3'b000, 0, 0, 0, 1));
    put(14, 0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 1));
    put(15, 0, 0, 3'b011, ex(3'b100, 0, 1, 3'b000, 0, 0, 0, 0));
    for (int i = 16; i < 15 + T; i++) put(i, 0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 0, 0, 0, 0));
    put(15 + T, 0, 0, 3'b011, ex(3'b000, 0, 0, 3'b100, 1, 1, 0, 0));
    put(16 + T, 0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 0));
    repeat (2) @(posedge clk_2);
    #1;
    chk("reset", outs, '0);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) step(tbl[i].rm, tbl[i].rh, tbl[i].p, tbl[i].e, $sformatf("tbl%0d", i));
    step(0, 1, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 1), "door_req");
    step(0, 0, 3'b011, ex(3'b100, 0, 1, 3'b000, 0, 0, 0, 0), "door_grant");
    for (int k = 1; k < T; k++) step(0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 0, 0, 0, 0), $sformatf("door_hold%0d", k));
    step(0, 0, 3'b111, ex(3'b000, 0, 0, 3'b000, 0, 0, 0, 0), "door_wins");
    step(0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 0), "door_open");
    step(0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 0), "door_no_to");
    for (int k = 1; k <= 16; k++)
      step(0, 1, 3'b111, ex(3'b000, 0, 0, 3'b000, 0, 0, 0, k > 15 ? 15 : k), $sformatf("sat%0d", k));
    step(0, 0, 3'b011, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 15), "sat_free");
    step(0, 1, 3'b011, ex(3'b100, 0, 1, 3'b000, 0, 0, 0, 15), "sat_req_grant");
    step(0, 0, 3'b000, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 15), "mid_open");
    step(0, 0, 3'b000, ex(3'b010, 0, 1, 3'b000, 1, 0, 0, 14), "mid_grant_b");
    step(0, 0, 3'b000, ex(3'b000, 0, 0, 3'b000, 1, 0, 0, 14), "mid_wait1");
    step(0, 0, 3'b000, ex(3'b000, 0, 0, 3'b000, 1, 0, 0, 14), "mid_wait2");
    reset_n = 1'b0;
    #1;
    chk("rst_mid", outs, '0);
    repeat (3) @(posedge clk_2);
    #1;
    chk("rst_hold", outs, '0);
    reset_n = 1'b1;
    step(0, 0, 3'b000, ex(3'b000, 0, 0, 3'b000, 1, 1, 0, 0), "post_rst");
    step(1, 1, 3'b000, ex(3'b000, 0, 0, 3'b000, 1, 1, 1, 1), "post_both_req");
    step(0, 0, 3'b000, ex(3'b001, 1, 0, 3'b000, 1, 1, 0, 1), "post_prio_w");
    step(0, 0, 3'b000, ex(3'b010, 0, 1, 3'b000, 1, 1, 0, 0), "post_rr_b");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
